bg_block_mover: RTL and testbench
=================================

Name: bg_block_mover

Overview:
- Memory-side partner of the GPU backend's BG block cache. Takes the backend's 16-pixel (256-bit) block exports and writes them to VRAM as a masked save, skipping pixels the backend did not write.
- Fetches requested BG blocks from VRAM and hands them back to the backend as a single-clock import pulse.
- Sits between the backend and the VRAM memory arbiter; the memory bus is 64-bit (4 pixels per beat, 4 beats per block).

Parameters:
- SKIP_EMPTY_BEATS, 1, when 1 write beats with an all-zero pixel mask are not issued; when 0 every beat is issued.

Ports:
- clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_saveReq  in  1  pulse: save i_saveBlock to i_saveAdr; sampled only when o_busy=0
- i_saveAdr  in  15  block address {y[8:0], x[9:4]}
- i_saveBlock  in  256  16 pixels; pixel n at bits [16n+15:16n]
- i_saveMask  in  16  bit n=1 means pixel n is written
- i_loadReq  in  1  pulse: fetch block at i_loadAdr; sampled only when o_busy=0
- i_loadAdr  in  15  block address
- o_busy  out  1  1 from the cycle after an accepted request until the cycle after completion
- o_importBGBlockSingleClock  out  1  one-cycle pulse; loaded block is valid
- o_importedBGBlock  out  256  loaded block, same pixel layout
- o_memCmdValid  out  1  memory command valid
- i_memCmdReady  in  1  command accepted when valid&ready
- o_memCmdWrite  out  1  1=write, 0=read
- o_memAdr  out  17  64-bit word address {blockAdr, beat[1:0]}
- o_memWData  out  64  write data for the beat (pixels 4b..4b+3)
- o_memWMask  out  4  per-pixel (16-bit lane) write enable
- i_memRValid  in  1  read data beat valid; beats return in issue order
- i_memRData  in  64  read data

Behaviour:
- Reset (async, i_nrst=0): state IDLE; o_busy, o_memCmdValid, o_memCmdWrite, o_importBGBlockSingleClock = 0; o_memAdr, o_memWData, o_memWMask, o_importedBGBlock = 0.
  - In-flight transfer is abandoned; read beats arriving after reset release are ignored while IDLE.
- States: IDLE, WRITE, READ, DONE.
- IDLE, request capture: on i_saveReq or i_loadReq, latch the address/data/mask of each asserted request; o_busy=1 next cycle. Requests while busy are ignored (the backend must check o_busy).
- IDLE, transitions:
  - Save request → WRITE.
  - Load only → READ.
  - Both in the same cycle → WRITE, then READ. Save completes before load, so a same-address load returns the saved data.
  - Save with mask=0 (and SKIP_EMPTY_BEATS=1) → directly to READ if a load is pending, else IDLE; no memory traffic.
- WRITE:
  - Beat b = 0..3 in order. Data = block[64b+63:64b]; mask = mask[4b+3:4b].
  - Beats with zero mask are skipped when SKIP_EMPTY_BEATS=1. Skipping costs 0 cycles: the next non-empty beat is presented in the same cycle.
  - o_memCmdValid held with stable adr/data/mask until ready.
  - After the last issued beat is accepted → READ if a load is pending, else IDLE (o_busy drops the same cycle).
- READ:
  - Issue 4 read commands, beats 0..3 (o_memWMask=0).
  - Independently count returned beats 0..3; beat k lands in o_importedBGBlock[64k+63:64k].
  - Commands and returns may overlap. Data returning in the same cycle a command is accepted is legal.
  - After the 4th beat returns → DONE.
- DONE: o_importBGBlockSingleClock=1 for exactly one cycle, o_busy=1 in this cycle; next cycle IDLE, o_busy=0.
  - o_importedBGBlock holds its value until the next load's first beat.
- Latency, save with all beats issued and ready tied high: 4 write cycles.
- Latency, load with ready high and read latency L: pulse at cycle 4+L after entering READ at the earliest (cmd 3 at cycle 3, data at 3+L, DONE next).
- Address: o_memAdr = {blockAdr, beat}; no wrap between blocks. Blocks 0x7FFF map to words 0x1FFFC..0x1FFFF.
- i_memRValid outside READ is ignored.

Test Plan:
- Save only: adr=0x0123, mask=0xFFFF, ready=1 → 4 write cmds, adr 0x048C..0x048F, wmask=0xF each, data = block slices; o_busy low 5 cycles after the request.
- Sparse save: mask=0x00F0 → exactly 1 write cmd, adr {adr,2'b01}, wmask=0xF; mask=0x0000 → no commands, busy for 1 cycle.
- Load: adr=0x7FFF, read latency 3, data beats 0x1111…, 0x2222…, 0x3333…, 0x4444… → cmds 0x1FFFC..0x1FFFF; single import pulse; o_importedBGBlock = {0x4444…,0x3333…,0x2222…,0x1111…}.
- Simultaneous save+load to the same adr with a memory model → all writes precede reads; imported block equals the saved pixels where mask=1, old memory elsewhere.
- Backpressure: ready low for 5 cycles on write beat 1 → adr/data/mask stable throughout, no duplicate beat; new i_saveReq while busy ignored.
- Async reset asserted mid-READ after 2 beats → outputs 0 immediately; post-reset stray i_memRValid produces no import pulse; next load behaves normally.

Source files
------------

// File: rtl/bg_block_mover_if.sv
// Backend/VRAM-arbiter signal bundle for bg_block_mover.
// slave = the mover itself; master = whatever drives it (backend + memory side).
interface bg_block_mover_if;
  logic         i_saveReq;
  logic [14:0]  i_saveAdr;
  logic [255:0] i_saveBlock;
  logic [15:0]  i_saveMask;
  logic         i_loadReq;
  logic [14:0]  i_loadAdr;
  logic         o_busy;
  logic         o_importBGBlockSingleClock;
  logic [255:0] o_importedBGBlock;
  logic         o_memCmdValid;
  logic         i_memCmdReady;
  logic         o_memCmdWrite;
  logic [16:0]  o_memAdr;
  logic [63:0]  o_memWData;
  logic [3:0]   o_memWMask;
  logic         i_memRValid;
  logic [63:0]  i_memRData;

  modport slave (
    input  i_saveReq, i_saveAdr, i_saveBlock, i_saveMask, i_loadReq, i_loadAdr,
           i_memCmdReady, i_memRValid, i_memRData,
    output o_busy, o_importBGBlockSingleClock, o_importedBGBlock,
           o_memCmdValid, o_memCmdWrite, o_memAdr, o_memWData, o_memWMask
  );

  modport master (
    output i_saveReq, i_saveAdr, i_saveBlock, i_saveMask, i_loadReq, i_loadAdr,
           i_memCmdReady, i_memRValid, i_memRData,
    input  o_busy, o_importBGBlockSingleClock, o_importedBGBlock,
           o_memCmdValid, o_memCmdWrite, o_memAdr, o_memWData, o_memWMask
  );
endinterface

// File: rtl/bg_block_mover.sv
// Moves 16-pixel BG blocks between the backend block cache and VRAM:
// masked 4-beat saves, 4-beat loads returned as a single-clock import pulse.
module bg_block_mover #(
  parameter int SKIP_EMPTY_BEATS = 1
) (
  input logic              clk,
  input logic              i_nrst,
  bg_block_mover_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state, stateNxt;
  logic [14:0]   saveAdr, loadAdr;
  logic [255:0]  saveBlock;
  logic [15:0]   saveMask;
  logic          loadPending;
  logic [1:0]    wrBeat;
  logic [2:0]    rdCmdCnt;
  logic [1:0]    rdRetCnt;
  logic [255:0]  importedBlock;
  logic [1:0]    curBeat;
  logic          beatFound, moreAfter, reqHasLive;
  logic          cmdFire, retFire;

  function automatic logic beatLive(input logic [15:0] m, input int b);
    return (SKIP_EMPTY_BEATS == 0) || (m[4*b +: 4] != 4'd0);
  endfunction

  // Pick the first live beat at or after wrBeat so empty beats cost no cycles.
  always_comb begin
    curBeat    = 2'd0;
    beatFound  = 1'b0;
    moreAfter  = 1'b0;
    reqHasLive = 1'b0;
    for (int b = 3; b >= 0; b--) begin
      if (2'(b) >= wrBeat && beatLive(saveMask, b)) begin
        curBeat   = 2'(b);
        beatFound = 1'b1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (beatFound && 2'(b) > curBeat && beatLive(saveMask, b)) moreAfter = 1'b1;
      if (beatLive(bus.i_saveMask, b)) reqHasLive = 1'b1;
    end
  end

  always_comb begin
    bus.o_memCmdValid = 1'b0;
    bus.o_memCmdWrite = 1'b0;
    bus.o_memAdr      = 17'd0;
    bus.o_memWData    = 64'd0;
    bus.o_memWMask    = 4'd0;
    case (state)
      WRITE: if (beatFound) begin
        bus.o_memCmdValid = 1'b1;
        bus.o_memCmdWrite = 1'b1;
        bus.o_memAdr      = {saveAdr, curBeat};
        bus.o_memWData    = saveBlock[{curBeat, 6'd0} +: 64];
        bus.o_memWMask    = saveMask[{curBeat, 2'd0} +: 4];
      end
      READ: if (!rdCmdCnt[2]) begin
        bus.o_memCmdValid = 1'b1;
        bus.o_memAdr      = {loadAdr, rdCmdCnt[1:0]};
      end
      default: ;
    endcase
  end

  assign cmdFire                        = bus.o_memCmdValid && bus.i_memCmdReady;
  assign retFire                        = (state == READ) && bus.i_memRValid;
  assign bus.o_busy                     = (state != IDLE);
  assign bus.o_importBGBlockSingleClock = (state == DONE);
  assign bus.o_importedBGBlock          = importedBlock;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        // An empty save paired with a load goes straight to reading.
        if (bus.i_saveReq && (reqHasLive || !bus.i_loadReq)) stateNxt = WRITE;
        else if (bus.i_loadReq)                               stateNxt = READ;
      end
      WRITE: if (!beatFound || (cmdFire && !moreAfter)) stateNxt = loadPending ? READ : IDLE;
      READ:  if (retFire && rdRetCnt == 2'd3) stateNxt = DONE;
      DONE:  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state         <= IDLE;
      loadPending   <= 1'b0;
      wrBeat        <= 2'd0;
      rdCmdCnt      <= 3'd0;
      rdRetCnt      <= 2'd0;
      importedBlock <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE) loadPending <= bus.i_loadReq;

      if (state != WRITE)  wrBeat <= 2'd0;
      else if (cmdFire)    wrBeat <= curBeat + 2'd1;

      if (state != READ)   rdCmdCnt <= 3'd0;
      else if (cmdFire)    rdCmdCnt <= rdCmdCnt + 3'd1;

      if (state != READ)   rdRetCnt <= 2'd0;
      else if (retFire)    rdRetCnt <= rdRetCnt + 2'd1;

      if (retFire) importedBlock[{rdRetCnt, 6'd0} +: 64] <= bus.i_memRData;
    end
  end

  // Request payloads are only consumed in WRITE/READ, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (bus.i_saveReq) begin
        saveAdr   <= bus.i_saveAdr;
        saveBlock <= bus.i_saveBlock;
        saveMask  <= bus.i_saveMask;
      end
      if (bus.i_loadReq) loadAdr <= bus.i_loadAdr;
    end
  end

endmodule

// File: tb/tb_bg_block_mover.sv
// Bench for bg_block_mover: VRAM model with latency/backpressure, table vectors,
// hand-written corner sequences and randomized transactions vs. a pixel-level model.
module tb_bg_block_mover;

  logic clk = 1'b0;
  logic i_nrst;
  always #5 clk = ~clk;

  bg_block_mover_if bus ();

  bg_block_mover #(.SKIP_EMPTY_BEATS(1)) dut (
    .clk    (clk),
    .i_nrst (i_nrst),
    .bus    (bus)
  );

  typedef struct {
    bit          wr;
    logic [16:0] adr;
    logic [63:0] data;
    logic [3:0]  mask;
  } cmd_t;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  typedef struct {
    bit          sv;
    logic [14:0] sAdr;
    logic [15:0] msk;
    bit          ld;
    logic [14:0] lAdr;
    int          lat;
    int          expWrites;
    logic [16:0] expFirst;
    int          expEnd;
    bit          impConst;
  } vec_t;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  cmd_t        cmdLog[$];
  rd_t         rdQ[$];
  logic [63:0] simMem [logic [16:0]];
  logic [63:0] refMem [logic [16:0]];
  int          rdLat = 1;
  bit          readyRand = 1'b0;
  int          holdBeat = -1;
  int          holdLeft = 0;
  bit          strayRValid = 1'b0;
  int          pulseCnt = 0;
  logic [255:0] lastImport = '0;
  bit          prevStall = 1'b0;
  cmd_t        prevCmd, mCmd;
  logic        mRdy;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name,
                              input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic logic [63:0] memInit(input logic [16:0] a);
    return {47'd0, a} * 64'h9E3779B97F4A7C15;
  endfunction

  function automatic logic [63:0] simRd(input logic [16:0] a);
    if (simMem.exists(a)) return simMem[a];
    return memInit(a);
  endfunction

  function automatic logic [63:0] refRd(input logic [16:0] a);
    if (refMem.exists(a)) return refMem[a];
    return memInit(a);
  endfunction

  function automatic logic [255:0] packCmd(input cmd_t c);
    return {170'd0, c.wr, c.adr, c.mask, c.data};
  endfunction

  // Reference save: every pixel whose mask bit is set lands in its VRAM lane.
  function automatic void refSave(input logic [14:0] a, input logic [255:0] blk,
                                  input logic [15:0] msk);
    for (int p = 0; p < 16; p++) begin
      if (msk[p]) begin
        logic [16:0] w;
        logic [63:0] word;
        w    = {a, 2'(p / 4)};
        word = refRd(w);
        word[16 * (p % 4) +: 16] = blk[16 * p +: 16];
        refMem[w] = word;
      end
    end
  endfunction

  // VRAM model: decides ready/return for the coming edge, logs accepted commands.
  always @(negedge clk) begin
    if (!i_nrst) begin
      rdQ.delete();
      bus.i_memRValid   = 1'b0;
      bus.i_memRData    = 64'd0;
      bus.i_memCmdReady = 1'b1;
      prevStall = 1'b0;
    end else begin
      mRdy = readyRand ? ($urandom_range(3) != 0) : 1'b1;
      if (holdBeat >= 0 && holdLeft > 0 && bus.o_memCmdValid && bus.o_memCmdWrite &&
          bus.o_memAdr[1:0] == 2'(holdBeat)) begin
        mRdy = 1'b0;
        holdLeft--;
      end
      bus.i_memCmdReady = mRdy;

      if (strayRValid) begin
        bus.i_memRValid = 1'b1;
        bus.i_memRData  = 64'hDEAD_BEEF_CAFE_F00D;
      end else if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
        bus.i_memRValid = 1'b1;
        bus.i_memRData  = rdQ[0].data;
        void'(rdQ.pop_front());
      end else begin
        bus.i_memRValid = 1'b0;
        bus.i_memRData  = 64'd0;
      end

      mCmd = '{wr: bus.o_memCmdWrite, adr: bus.o_memAdr, data: bus.o_memWData, mask: bus.o_memWMask};
      if (prevStall)
        chk(bus.o_memCmdValid && packCmd(mCmd) == packCmd(prevCmd), "stall_stable",
            packCmd(mCmd), packCmd(prevCmd));
      if (bus.o_memCmdValid && mRdy) begin
        cmdLog.push_back(mCmd);
        if (mCmd.wr) begin
          logic [63:0] word;
          word = simRd(mCmd.adr);
          for (int p = 0; p < 4; p++)
            if (mCmd.mask[p]) word[16 * p +: 16] = mCmd.data[16 * p +: 16];
          simMem[mCmd.adr] = word;
        end else begin
          rdQ.push_back('{due: cyc + rdLat, data: simRd(mCmd.adr)});
        end
      end
      prevStall = bus.o_memCmdValid && !mRdy;
      prevCmd   = mCmd;

      if (bus.o_importBGBlockSingleClock) begin
        pulseCnt++;
        lastImport = bus.o_importedBGBlock;
      end
    end
  end

  function automatic logic [255:0] rndBlock();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32 * k +: 32] = $urandom;
    return b;
  endfunction

  task automatic waitIdle(input int c0, output int relEnd);
    int n;
    n = 0;
    while (bus.o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(n < 300, "busy_timeout", 256'(n), 256'(300));
    relEnd = cyc - c0;
  endtask

  task automatic doTxn(input bit sv, input logic [14:0] sAdr, input logic [255:0] blk,
                       input logic [15:0] msk, input bit ld, input logic [14:0] lAdr,
                       input int lat, output int nWrites, output logic [16:0] firstW,
                       output int relEnd);
    cmd_t         exp[$];
    logic [255:0] expImp;
    int           start, p0, c0, nAct;
    expImp = '0;
    rdLat  = lat;
    if (sv) begin
      for (int b = 0; b < 4; b++)
        if (msk[4 * b +: 4] != 4'd0)
          exp.push_back('{wr: 1'b1, adr: {sAdr, 2'(b)}, data: blk[64 * b +: 64], mask: msk[4 * b +: 4]});
      refSave(sAdr, blk, msk);
    end
    if (ld) begin
      for (int b = 0; b < 4; b++) begin
        exp.push_back('{wr: 1'b0, adr: {lAdr, 2'(b)}, data: 64'd0, mask: 4'd0});
        expImp[64 * b +: 64] = refRd({lAdr, 2'(b)});
      end
    end
    start = cmdLog.size();
    p0    = pulseCnt;
    @(negedge clk);
    chk(!bus.o_busy, "idle_before_req", 256'(bus.o_busy), 256'(0));
    c0 = cyc;
    bus.i_saveReq   = sv;
    bus.i_saveAdr   = sAdr;
    bus.i_saveBlock = blk;
    bus.i_saveMask  = msk;
    bus.i_loadReq   = ld;
    bus.i_loadAdr   = lAdr;
    @(negedge clk);
    bus.i_saveReq   = 1'b0;
    bus.i_loadReq   = 1'b0;
    bus.i_saveAdr   = ~sAdr;
    bus.i_saveBlock = ~blk;
    bus.i_saveMask  = ~msk;
    bus.i_loadAdr   = ~lAdr;
    waitIdle(c0, relEnd);

    nAct = cmdLog.size() - start;
    chk(nAct == exp.size(), "cmd_count", 256'(nAct), 256'(exp.size()));
    nWrites = 0;
    firstW  = 17'd0;
    for (int i = 0; i < nAct; i++) begin
      cmd_t a;
      a = cmdLog[start + i];
      if (a.wr) begin
        if (nWrites == 0) firstW = a.adr;
        nWrites++;
      end
      if (i < exp.size()) begin
        if (!a.wr) a.data = 64'd0;
        chk(packCmd(a) == packCmd(exp[i]), "cmd_entry", packCmd(a), packCmd(exp[i]));
      end
    end
    chk(pulseCnt - p0 == (ld ? 1 : 0), "pulse_count", 256'(pulseCnt - p0), 256'(ld ? 1 : 0));
    if (ld) begin
      chk(lastImport == expImp, "import_data", lastImport, expImp);
      chk(bus.o_importedBGBlock == expImp, "import_hold", bus.o_importedBGBlock, expImp);
    end
  endtask

  initial begin
    vec_t         vecs[7];
    int           nW, relEnd, c0, p0, start, nWr;
    logic [16:0]  fW;
    logic [255:0] blk;
    logic [14:0]  pool[6];
    logic [255:0] impConst;

    vecs[0] = '{1, 15'h0123, 16'hFFFF, 0, 15'h0000, 1, 4, 17'h0048C, 5, 0};
    vecs[1] = '{1, 15'h0200, 16'h00F0, 0, 15'h0000, 1, 1, 17'h00801, 2, 0};
    vecs[2] = '{1, 15'h0300, 16'h0000, 0, 15'h0000, 1, 0, 17'h00000, 2, 0};
    vecs[3] = '{1, 15'h0400, 16'h8001, 0, 15'h0000, 1, 2, 17'h01000, 3, 0};
    vecs[4] = '{0, 15'h0000, 16'h0000, 1, 15'h7FFF, 3, 0, 17'h00000, 9, 1};
    vecs[5] = '{1, 15'h0123, 16'h0F0F, 1, 15'h0123, 2, 2, 17'h0048C, 10, 0};
    vecs[6] = '{1, 15'h0500, 16'h0000, 1, 15'h0500, 1, 0, 17'h00000, 7, 0};
    impConst = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    pool = '{15'h0010, 15'h0011, 15'h0012, 15'h0013, 15'h7FFE, 15'h7FFF};

    for (int b = 0; b < 4; b++) begin
      simMem[{15'h7FFF, 2'(b)}] = impConst[64 * b +: 64];
      refMem[{15'h7FFF, 2'(b)}] = impConst[64 * b +: 64];
    end

    i_nrst          = 1'b0;
    bus.i_saveReq   = 1'b0;
    bus.i_saveAdr   = '0;
    bus.i_saveBlock = '0;
    bus.i_saveMask  = '0;
    bus.i_loadReq   = 1'b0;
    bus.i_loadAdr   = '0;
    repeat (3) @(negedge clk);
    chk(!bus.o_busy && !bus.o_memCmdValid && !bus.o_memCmdWrite && !bus.o_importBGBlockSingleClock,
        "reset_ctrl", {bus.o_busy, bus.o_memCmdValid, bus.o_memCmdWrite, bus.o_importBGBlockSingleClock}, 256'(0));
    chk(bus.o_memAdr == 0 && bus.o_memWData == 0 && bus.o_memWMask == 0, "reset_bus",
        {bus.o_memAdr, bus.o_memWData, bus.o_memWMask}, 256'(0));
    chk(bus.o_importedBGBlock == '0, "reset_import", bus.o_importedBGBlock, 256'(0));
    i_nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors with ready tied high so cycle counts are exact.
    readyRand = 1'b0;
    for (int i = 0; i < 7; i++) begin
      doTxn(vecs[i].sv, vecs[i].sAdr, rndBlock(), vecs[i].msk, vecs[i].ld, vecs[i].lAdr,
            vecs[i].lat, nW, fW, relEnd);
      chk(nW == vecs[i].expWrites, "vec_writes", 256'(nW), 256'(vecs[i].expWrites));
      if (vecs[i].expWrites > 0) chk(fW == vecs[i].expFirst, "vec_first_adr", 256'(fW), 256'(vecs[i].expFirst));
      chk(relEnd == vecs[i].expEnd, "vec_busy_cycles", 256'(relEnd), 256'(vecs[i].expEnd));
      if (vecs[i].impConst) chk(lastImport == impConst, "vec_import_const", lastImport, impConst);
    end

    // Backpressure on write beat 1; a request while busy must be dropped.
    holdBeat = 1;
    holdLeft = 5;
    blk      = rndBlock();
    refSave(15'h0055, blk, 16'hFFFF);
    start = cmdLog.size();
    p0    = pulseCnt;
    @(negedge clk);
    c0 = cyc;
    bus.i_saveReq = 1'b1; bus.i_saveAdr = 15'h0055; bus.i_saveBlock = blk; bus.i_saveMask = 16'hFFFF;
    @(negedge clk);
    bus.i_saveReq = 1'b0;
    repeat (2) @(negedge clk);
    chk(bus.o_busy, "busy_during_stall", 256'(bus.o_busy), 256'(1));
    bus.i_saveReq = 1'b1; bus.i_saveAdr = 15'h0066; bus.i_saveBlock = ~blk; bus.i_saveMask = 16'hFFFF;
    bus.i_loadReq = 1'b1; bus.i_loadAdr = 15'h0066;
    @(negedge clk);
    bus.i_saveReq = 1'b0;
    bus.i_loadReq = 1'b0;
    waitIdle(c0, relEnd);
    chk(relEnd == 10, "stall_busy_cycles", 256'(relEnd), 256'(10));
    chk(holdLeft == 0, "stall_applied", 256'(holdLeft), 256'(0));
    chk(cmdLog.size() - start == 4, "stall_cmd_count", 256'(cmdLog.size() - start), 256'(4));
    nWr = 0;
    for (int i = start; i < cmdLog.size(); i++) begin
      cmd_t e;
      e = '{wr: 1'b1, adr: {15'h0055, 2'(nWr)}, data: blk[64 * nWr +: 64], mask: 4'hF};
      if (nWr < 4) chk(packCmd(cmdLog[i]) == packCmd(e), "stall_cmd", packCmd(cmdLog[i]), packCmd(e));
      nWr++;
    end
    chk(pulseCnt == p0, "busy_req_ignored", 256'(pulseCnt - p0), 256'(0));
    holdBeat = -1;

    // Asynchronous reset in the middle of a load, then stray read data.
    rdLat = 1;
    @(negedge clk);
    c0 = cyc;
    bus.i_loadReq = 1'b1; bus.i_loadAdr = 15'h0055;
    @(negedge clk);
    bus.i_loadReq = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.o_busy && bus.o_importedBGBlock[127:0] == {blk[127:64], blk[63:0]}, "mid_read_two_beats",
        bus.o_importedBGBlock, {128'd0, blk[127:0]});
    #1 i_nrst = 1'b0;
    #1;
    chk(!bus.o_busy && !bus.o_memCmdValid && !bus.o_importBGBlockSingleClock, "async_reset_ctrl",
        {bus.o_busy, bus.o_memCmdValid, bus.o_importBGBlockSingleClock}, 256'(0));
    chk(bus.o_memAdr == 0 && bus.o_memWMask == 0 && bus.o_importedBGBlock == '0, "async_reset_data",
        {bus.o_memAdr, bus.o_memWMask, bus.o_importedBGBlock[127:0]}, 256'(0));
    repeat (2) @(negedge clk);
    i_nrst = 1'b1;
    p0 = pulseCnt;
    strayRValid = 1'b1;
    repeat (3) @(negedge clk);
    strayRValid = 1'b0;
    repeat (3) @(negedge clk);
    chk(pulseCnt == p0 && !bus.o_busy, "stray_rvalid_ignored", 256'(pulseCnt - p0), 256'(0));
    chk(bus.o_importedBGBlock == '0, "stray_no_capture", bus.o_importedBGBlock, 256'(0));
    doTxn(1'b0, 15'h0, '0, 16'h0, 1'b1, 15'h0055, 2, nW, fW, relEnd);

    // Randomized transactions with random ready and latency.
    readyRand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit          sv, ld;
      logic [14:0] sA, lA;
      logic [15:0] m;
      sv = ($urandom_range(3) != 0);
      ld = !sv || ($urandom_range(1) == 1);
      sA = pool[$urandom_range(5)];
      lA = ($urandom_range(1) == 1) ? sA : pool[$urandom_range(5)];
      for (int k = 0; k < 4; k++) m[4 * k +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom);
      doTxn(sv, sA, rndBlock(), m, ld, lA, $urandom_range(4, 1), nW, fW, relEnd);
    end
    readyRand = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

endmodule
